// File: rtl/wptr_full_status.sv
// Write-side pointer and status logic for an asynchronous FIFO.
// Keeps the binary and Gray write pointers, the registered full flag,
// an occupancy estimate against the synchronized read pointer, a
// programmable almost-full flag and a sticky overflow flag.
module wptr_full_status #(
  parameter int ADDRSIZE   = 4,
  parameter int AF_DEFAULT = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   af_thresh,
  input  logic                af_load,
  input  logic                clr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int                DEPTH    = 2**ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_V  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AF_RESET =
    (ADDRSIZE+1)'((AF_DEFAULT > DEPTH) ? DEPTH : AF_DEFAULT);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_af_reg;

  logic [ADDRSIZE:0] w_wbinnext;
  logic [ADDRSIZE:0] w_wgraynext;
  logic [ADDRSIZE:0] w_rq2_bin;
  logic [ADDRSIZE:0] w_occ_next;
  logic [ADDRSIZE:0] w_full_pattern;
  logic              w_full_next;
  logic [ADDRSIZE:0] w_af_sat;

  // A write is accepted only while the FIFO is not already full.
  assign wclken = winc & ~wfull;
  assign waddr  = r_wbin[ADDRSIZE-1:0];

  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, wclken};
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that is the two MSBs inverted, the rest equal.
  assign w_full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  assign w_full_next    = (w_wgraynext == w_full_pattern);

  // Gray-to-binary of the synchronized read pointer: each binary bit is the
  // XOR of all Gray bits from the MSB down to that position.
  always_comb begin
    // NOTE: give every bit a value up front so no path leaves it unassigned
    // and no latch is inferred.
    w_rq2_bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      w_rq2_bin[i] = ^(wq2_rptr >> i);
    end
  end

  // Modulo subtraction gives the occupancy even across pointer wrap.
  assign w_occ_next = w_wbinnext - w_rq2_bin;

  // Thresholds beyond the FIFO depth could never be reached; clamp them.
  assign w_af_sat = (af_thresh > DEPTH_V) ? DEPTH_V : af_thresh;

  // Pointer, full and occupancy registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    // NOTE: every register here is a flop with a defined reset value, and all
    // updates are non-blocking so each reads the pre-edge values of the others.
    if (!wrst_n) begin
      r_wbin       <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      wcount       <= '0;
      walmost_full <= 1'b0;
    end else begin
      r_wbin       <= w_wbinnext;
      wptr         <= w_wgraynext;
      wfull        <= w_full_next;
      wcount       <= w_occ_next;
      walmost_full <= (w_occ_next >= r_af_reg);
    end
  end

  // Almost-full threshold register; a new value affects the flag one edge later.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_af_reg <= AF_RESET;
    end else if (af_load) begin
      r_af_reg <= w_af_sat;
    end
  end

  // Sticky overflow: a rejected write sets it and wins over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (clr_ovf) begin
      woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full_status.sv
// Self-checking bench for wptr_full_status (ADDRSIZE=4). A behavioural model
// computes expected post-edge outputs at stimulus time, queues them, and the
// queue is popped and compared after each rising edge.
module tb_wptr_full_status;

  localparam int AW = 4;

  typedef struct {
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic          wfull;
    logic [AW:0]   wcount;
    logic          walmost;
    logic          wovf;
  } exp_t;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   af_thresh;
  logic          af_load;
  logic          clr_ovf;
  logic [AW-1:0] waddr;
  logic          wclken;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wcount;
  logic          woverflow;

  wptr_full_status #(.ADDRSIZE(AW)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .af_thresh    (af_thresh),
    .af_load      (af_load),
    .clr_ovf      (clr_ovf),
    .waddr        (waddr),
    .wclken       (wclken),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  // Model state
  logic [AW:0] m_wbin;
  logic        m_full;
  logic        m_ovf;
  int          m_af;
  logic [AW:0] tb_rbin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wbin  = '0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_af    = 14;
    tb_rbin = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"},   wptr,         0);
    check({tag, "_waddr"},  waddr,        0);
    check({tag, "_wfull"},  wfull,        0);
    check({tag, "_wcount"}, wcount,       0);
    check({tag, "_walmf"},  walmost_full, 0);
    check({tag, "_wovf"},   woverflow,    0);
  endtask

  // Reset asserted asynchronously in the middle of a low clock phase.
  task automatic do_reset(input string tag);
    @(negedge wclk);
    #2 wrst_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    sb_q.delete();
    @(negedge wclk);
    winc = 1'b0; clr_ovf = 1'b0; af_load = 1'b0; af_thresh = '0;
    wq2_rptr = '0;
    wrst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, then compare after the edge.
  task automatic step(input logic wi, input logic cl = 1'b0,
                      input logic ld = 1'b0, input logic [AW:0] th = '0);
    exp_t        e;
    logic        ce;
    logic [AW:0] nb, occ;
    @(negedge wclk);
    winc = wi; clr_ovf = cl; af_load = ld; af_thresh = th;
    wq2_rptr = gray(tb_rbin);
    ce = wi & ~m_full;
    #1 check("wclken", wclken, ce);
    nb  = m_wbin + (ce ? 5'd1 : 5'd0);
    occ = nb - tb_rbin;
    e.wptr    = gray(nb);
    e.waddr   = nb[AW-1:0];
    e.wfull   = (occ == 5'd16);
    e.wcount  = occ;
    e.walmost = (int'(occ) >= m_af);
    e.wovf    = (wi && m_full) ? 1'b1 : (cl ? 1'b0 : m_ovf);
    sb_q.push_back(e);
    m_wbin = nb;
    m_full = e.wfull;
    m_ovf  = e.wovf;
    if (ld) m_af = (int'(th) > 16) ? 16 : int'(th);
    @(posedge wclk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("wptr",   wptr,         e.wptr);
      check("waddr",  waddr,        e.waddr);
      check("wfull",  wfull,        e.wfull);
      check("wcount", wcount,       e.wcount);
      check("walmf",  walmost_full, e.walmost);
      check("wovf",   woverflow,    e.wovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW:0] prev;
    wrst_n = 1'b0; winc = 1'b0; clr_ovf = 1'b0; af_load = 1'b0;
    af_thresh = '0; wq2_rptr = '0;
    model_reset();
    #12 check_all_zero("rst");
    check("rst_wclken", wclken, 0);
    @(negedge wclk) wrst_n = 1'b1;

    // Fill 16 with read pointer at 0; default threshold 14 exercised by the model.
    for (int i = 0; i < 16; i++) step(1'b1);
    check("full_wfull",  wfull,  1);
    check("full_wptr",   wptr,   5'b11000);
    check("full_wcount", wcount, 16);
    // Write while full -> rejected, overflow sticky.
    step(1'b1);
    check("ovf_set",   woverflow, 1);
    check("ovf_wptr",  wptr,      5'b11000);
    step(1'b0, 1'b1);
    check("ovf_clr",   woverflow, 0);

    // Drain 4 entries on the read side.
    tb_rbin = 5'd4;
    step(1'b0);
    check("drain_wfull",  wfull,  0);
    check("drain_wcount", wcount, 12);
    for (int i = 0; i < 4; i++) step(1'b1);
    check("refill_wfull", wfull, 1);
    // Overflow and clear in the same cycle: set wins.
    step(1'b1, 1'b1);
    check("ovf_prio", woverflow, 1);
    step(1'b0, 1'b1);

    // Almost-full at 10.
    do_reset("rst2");
    step(1'b0, 1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      if (i == 8) begin
        check("af9_flag",  walmost_full, 0);
        check("af9_count", wcount,       9);
      end
    end
    check("af10_flag",  walmost_full, 1);
    check("af10_count", wcount,       10);
    // Saturating threshold: 31 -> 16.
    step(1'b0, 1'b0, 1'b1, 5'd31);
    for (int i = 0; i < 6; i++) step(1'b1);
    check("afsat_flag", walmost_full, 1);

    // Threshold 0 -> flag high even when empty.
    do_reset("rst3");
    step(1'b0, 1'b0, 1'b1, 5'd0);
    step(1'b0);
    check("af0_flag", walmost_full, 1);

    // Wrap with read pointer trailing by 3.
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 40; i++) begin
      prev    = wptr;
      tb_rbin = m_wbin - 5'd2;
      step(1'b1);
      check("wrap_1bit",  $countones(wptr ^ prev), 1);
      check("wrap_count", wcount, 3);
    end

    // Reset mid-operation at occupancy 7, with a write in flight.
    do_reset("rst4");
    for (int i = 0; i < 7; i++) step(1'b1);
    check("mid_count", wcount, 7);
    do_reset("mid");
    // Default threshold 14 restored: flag low at 13, high at 14.
    for (int i = 0; i < 14; i++) begin
      step(1'b1);
      if (i == 12) check("afdef13", walmost_full, 0);
    end
    check("afdef14", walmost_full, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
